// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default datapath widths, the canonical NOP and the IF/ID payload.
package pipeline_pkg;

    localparam int unsigned DEF_INSTR_W = 32;
    localparam int unsigned DEF_PC_W    = 64;

    // addi x0, x0, 0
    localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_PC_W-1:0]    pc;
    } ifid_entry_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register with optional second (skid) entry and flush.
module pipe_skid_buf #(
    parameter int unsigned DATA_W  = 96,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic                rdy_q, rdy_d;
    logic                accept, drain;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    // Registered ready with the skid entry; otherwise pass back-pressure straight through.
    assign in_ready  = SKID_EN ? rdy_q : (!out_valid || out_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        accept  = in_valid && in_ready;
        drain   = out_valid && out_ready;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_d = in_data;
                    end else if (accept && SKID_EN) begin
                        skid_d  = in_data;
                        state_d = TWO;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // Skid always drains after main to keep program order.
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        rdy_d = (state_d != TWO);
    end

endmodule

// File: rtl/ifid_pipe_stage.sv
// IF/ID pipeline register: handshake buffer, NOP bubble injection and saturating stall counter.
module ifid_pipe_stage #(
    parameter int unsigned          INSTR_W   = pipeline_pkg::DEF_INSTR_W,
    parameter int unsigned          PC_W      = pipeline_pkg::DEF_PC_W,
    parameter bit                   SKID_EN   = 1'b1,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(pipeline_pkg::NOP_INSTR),
    parameter int unsigned          CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    input  logic               flush,
    output logic [CNT_W-1:0]   stall_cnt,
    input  logic               stall_clr
);

    localparam int unsigned ENTRY_W = INSTR_W + PC_W;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    entry_t             in_entry;
    entry_t             main_entry;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    assign in_entry.instr = in_instr;
    assign in_entry.pc    = in_pc;

    pipe_skid_buf #(
        .DATA_W  (ENTRY_W),
        .SKID_EN (SKID_EN)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (main_entry)
    );

    // Bubble: decode sees a NOP at PC 0 whenever nothing valid is presented.
    assign out_instr = out_valid ? main_entry.instr : NOP_INSTR;
    assign out_pc    = out_valid ? main_entry.pc    : '0;
    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr) begin
            stall_cnt_d = '0;
        end else if (out_valid && !out_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ifid_pipe_stage.sv
// Bench for ifid_pipe_stage: skid and non-skid instances against a queue-based reference model.
module tb_ifid_pipe_stage;

    localparam int unsigned IW  = 32;
    localparam int unsigned PW  = 64;
    localparam int unsigned CW  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          CNT_MAX = 15;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [PW-1:0] pc;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, out_ready, flush, stall_clr;
    logic [IW-1:0] in_instr;
    logic [PW-1:0] in_pc;

    logic          rdy1, ov1, rdy0, ov0;
    logic [IW-1:0] oi1, oi0;
    logic [PW-1:0] op1, op0;
    logic [CW-1:0] sc1, sc0;

    ent_t q1[$];
    ent_t q0[$];
    int   cnt1, cnt0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ifid_pipe_stage #(.SKID_EN(1'b1), .CNT_W(CW)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov1), .out_ready(out_ready),
        .out_instr(oi1), .out_pc(op1), .flush(flush), .stall_cnt(sc1), .stall_clr(stall_clr)
    );

    ifid_pipe_stage #(.SKID_EN(1'b0), .CNT_W(CW)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov0), .out_ready(out_ready),
        .out_instr(oi0), .out_pc(op0), .flush(flush), .stall_cnt(sc0), .stall_clr(stall_clr)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ready(input int sz, input bit skid);
        if (skid) return sz < 2;
        return (sz == 0) || out_ready;
    endfunction

    task automatic check_dut(input string tag, input logic rdy, input logic ov,
                             input logic [IW-1:0] oi, input logic [PW-1:0] op,
                             input logic [CW-1:0] sc, input bit skid, input ent_t q[$],
                             input int cnt);
        logic [IW-1:0] ei;
        logic [PW-1:0] ep;
        ei = NOP;
        ep = '0;
        if (q.size() > 0) begin
            ei = q[0].instr;
            ep = q[0].pc;
        end
        check_val({tag, ".in_ready"},  64'(rdy), 64'(exp_ready(q.size(), skid)));
        check_val({tag, ".out_valid"}, 64'(ov),  64'(q.size() > 0));
        check_val({tag, ".out_instr"}, 64'(oi),  64'(ei));
        check_val({tag, ".out_pc"},    op,       ep);
        check_val({tag, ".stall_cnt"}, 64'(sc),  64'(cnt));
    endtask

    // Called at a falling edge with inputs driven; checks, then advances model across the rising edge.
    task automatic tick();
        bit   a1, d1, s1, a0, d0, s0;
        ent_t e;
        #1;
        check_dut("skid", rdy1, ov1, oi1, op1, sc1, 1'b1, q1, cnt1);
        check_dut("flat", rdy0, ov0, oi0, op0, sc0, 1'b0, q0, cnt0);
        e  = '{instr: in_instr, pc: in_pc};
        a1 = in_valid && exp_ready(q1.size(), 1'b1);
        d1 = (q1.size() > 0) && out_ready;
        s1 = (q1.size() > 0) && !out_ready;
        a0 = in_valid && exp_ready(q0.size(), 1'b0);
        d0 = (q0.size() > 0) && out_ready;
        s0 = (q0.size() > 0) && !out_ready;
        @(posedge clk);
        if (flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (d1) void'(q1.pop_front());
            if (a1) q1.push_back(e);
            if (d0) void'(q0.pop_front());
            if (a0) q0.push_back(e);
        end
        if (stall_clr) cnt1 = 0; else if (s1 && cnt1 < CNT_MAX) cnt1++;
        if (stall_clr) cnt0 = 0; else if (s0 && cnt0 < CNT_MAX) cnt0++;
        @(negedge clk);
    endtask

    task automatic drive(input bit iv, input logic [PW-1:0] pc, input logic [IW-1:0] ins,
                         input bit ordy, input bit fl, input bit clr);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        stall_clr = clr;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; stall_clr = 1'b0;
        in_instr = '0; in_pc = '0;
        cnt1 = 0; cnt0 = 0;

        // Reset state
        @(negedge clk);
        #1;
        check_dut("rst_skid", rdy1, ov1, oi1, op1, sc1, 1'b1, q1, cnt1);
        check_dut("rst_flat", rdy0, ov0, oi0, op0, sc0, 1'b0, q0, cnt0);
        check_val("rst_nop", 64'(oi1), 64'(NOP));
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 1, 0, 0);

        // Single instruction, one-cycle latency
        drive(1, 64'h1000, 32'h0050_0093, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);

        // Back-to-back stream at full throughput
        for (int i = 0; i < 4; i++) drive(1, 64'(i * 4), 32'h0010_0093 + 32'(i), 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);

        // Back-pressure fills the skid, then drain
        drive(1, 64'h0, 32'h1111_0001, 0, 0, 0);
        drive(1, 64'h4, 32'h1111_0002, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 64'h8, 32'h1111_0003, 0, 0, 0);
        drive(1, 64'h8, 32'h1111_0003, 1, 0, 0);
        drive(1, 64'h8, 32'h1111_0003, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0);

        // Flush while full; 0x20 must vanish
        drive(1, 64'h10, 32'h2222_0001, 0, 0, 0);
        drive(1, 64'h14, 32'h2222_0002, 0, 0, 0);
        drive(1, 64'h20, 32'h2222_0003, 0, 1, 0);
        check_val("flush_rdy", 64'(rdy1), 64'd1);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 1, 0);

        // Stall counter saturation and clear
        drive(1, 64'h30, 32'h3333_0001, 0, 0, 0);
        for (int i = 0; i < (1 << CW) + 5; i++) drive(0, 0, 0, 0, 0, 0);
        check_val("sat_skid", 64'(sc1), 64'(CNT_MAX));
        check_val("sat_flat", 64'(sc0), 64'(CNT_MAX));
        drive(0, 0, 0, 0, 0, 1);
        check_val("clr_skid", 64'(sc1), 64'd0);
        drive(0, 0, 0, 1, 0, 0);

        // Asynchronous reset while full
        drive(1, 64'h40, 32'h4444_0001, 0, 0, 0);
        drive(1, 64'h44, 32'h4444_0002, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        check_val("arst_valid", 64'(ov1), 64'd0);
        check_val("arst_pc",    op1, 64'd0);
        check_val("arst_instr", 64'(oi1), 64'(NOP));
        check_val("arst_cnt",   64'(sc1), 64'd0);
        check_val("arst_rdy",   64'(rdy1), 64'd1);
        q1.delete(); q0.delete();
        cnt1 = 0; cnt0 = 0;
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 1, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            drive(($urandom % 4) != 0, {$urandom, $urandom}, $urandom,
                  ($urandom % 10) < 6, ($urandom % 32) == 0, ($urandom % 40) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifid_pipe_stage.md
Name: ifid_pipe_stage

Overview:
- Parametrised successor to the plain IF/ID latch: a fetch-to-decode pipeline register with valid/ready handshake, stall back-pressure, flush and an optional two-entry skid buffer.
- The skid buffer lets the fetch-side ready be fully registered.
- Sits between the PC/instruction-memory fetch stage and decode.
- Injects a NOP bubble whenever it presents no valid instruction.
- Provides a saturating stall counter for performance debug.

Parameters:
INSTR_W, 32, instruction width in bits
PC_W, 64, program-counter width in bits
SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
NOP_INSTR, 32'h00000013, encoding presented on out_instr while out_valid = 0
CNT_W, 16, stall-counter width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  fetch stage presents an instruction
in_ready  output  1  stage can accept; transfer occurs when in_valid & in_ready
in_instr  input  INSTR_W  fetched instruction
in_pc  input  PC_W  PC of fetched instruction
out_valid  output  1  decode-side instruction valid
out_ready  input  1  decode accepts; transfer occurs when out_valid & out_ready
out_instr  output  INSTR_W  instruction to decode (NOP_INSTR when out_valid = 0)
out_pc  output  PC_W  PC to decode (0 when out_valid = 0)
flush  input  1  discard all held entries (branch/exception redirect)
stall_cnt  output  CNT_W  saturating count of cycles with out_valid & !out_ready
stall_clr  input  1  synchronous clear of stall_cnt

Behaviour:
- Reset (reset = 0, asynchronous):
  - Both entries invalid; data registers cleared to 0; stall_cnt = 0.
  - out_valid = 0, out_instr = NOP_INSTR, out_pc = 0.
  - in_ready = 1 when SKID_EN = 1.
- Reset deassertion takes effect at the next rising clk. Reset mid-transfer drops all held entries with no partial state.
- Latency: one cycle from accepted input to out_valid. Full throughput (1 instr/cycle) when out_ready stays high.
- SKID_EN = 1, states EMPTY / ONE (main valid) / TWO (main + skid valid):
  - EMPTY: accept -> ONE.
  - ONE: accept & drain -> ONE (main reloaded); accept & !drain -> TWO (input to skid); drain & !accept -> EMPTY; otherwise hold.
  - TWO: in_ready = 0. Drain -> ONE (skid moves to main). No drain -> hold.
  - in_ready = (state != TWO), driven from a register, never from out_ready.
  - Order is preserved: skid always drains after main.
- SKID_EN = 0, single entry:
  - in_ready = !out_valid | out_ready (combinational).
  - Accept loads the entry; drain without accept empties it.
- Output muxing: out_instr/out_pc come from main; NOP_INSTR/0 are forced whenever out_valid = 0.
- Held data is stable: while out_valid & !out_ready, out_instr and out_pc must not change.
- Flush (has priority over every other event in the cycle):
  - Next state EMPTY; any input handshaking in the flush cycle is discarded.
  - A drain in the flush cycle still counts as consumed.
  - in_ready = 1 in the cycle after the flush.
  - Flush while EMPTY is a no-op.
- stall_cnt:
  - Increments by 1 per cycle with out_valid & !out_ready; saturates at all-ones with no wrap.
  - stall_clr sets 0 and wins over increment in the same cycle.
  - flush does not affect stall_cnt.
- Invariants: in_valid may be asserted irrespective of in_ready. No data loss and no duplication under any out_ready pattern.

Decomposition:
- Shared package (pipeline_pkg): NOP_INSTR constant, the default INSTR_W/PC_W, and a packed ifid_entry_t {instr, pc} typedef. Later ID/EX and EX/MEM stages reuse these.
- One natural sub-module, pipe_skid_buf: a generic two-entry skid buffer over a DATA_W payload carrying valid/ready and flush. ifid_pipe_stage wraps it with the payload packing, NOP muxing and stall counter.

Test Plan:
- Reset, then in_valid = 1 with pc = 0x1000, instr = 0x00500093, out_ready = 1 -> out_valid = 1 one cycle later with the same pc/instr; out_instr = 0x00000013 before that.
- Stream pc 0x0, 0x4, 0x8, 0xC back-to-back with out_ready = 1 -> one output per cycle, in order, in_ready constantly 1.
- SKID_EN = 1, out_ready = 0 while feeding 0x0, 0x4, 0x8 -> in_ready drops after two accepts, 0x8 held upstream, stall_cnt counts each blocked cycle. out_ready = 1 -> outputs 0x0, 0x4, 0x8, no loss or duplicate.
- State TWO, assert flush with in_valid = 1 (pc 0x20) -> next cycle out_valid = 0, out_instr = NOP, in_ready = 1, and 0x20 is never output.
- Hold out_valid = 1 with out_ready = 0 for 2^CNT_W + 5 cycles (CNT_W = 4) -> stall_cnt saturates at 15; stall_clr pulse -> 0.
- Assert reset = 0 asynchronously in state TWO mid-cycle -> out_valid drops immediately, stall_cnt = 0, and out_pc = 0 before the next clk edge.
